// File: rtl/issue_pkg.sv
// Shared issue-stage types: instruction record and window geometry.
// Reused by the fetch window and the downstream dependency checker.
package issue_pkg;

   typedef struct packed {
      logic [3:0] des;
      logic [3:0] source1;
      logic [3:0] source2;
      logic [3:0] op;
   } ins_t;

   localparam int WIN_DEPTH   = 8;
   localparam int ISSUE_LANES = 4;
   localparam int CNT_W       = 4;

endpackage

// File: rtl/ins_fetch_window_if.sv
// Enqueue lanes, presented slots, issue strobes and occupancy of the fetch window.
// master = window side, slave = producer/checker side.
interface ins_fetch_window_if;
   import issue_pkg::*;

   logic             flush_en;

   logic             enq_1_vld;
   logic [3:0]       enq_1_des;
   logic [3:0]       enq_1_source1;
   logic [3:0]       enq_1_source2;
   logic [3:0]       enq_1_op;
   logic             enq_2_vld;
   logic [3:0]       enq_2_des;
   logic [3:0]       enq_2_source1;
   logic [3:0]       enq_2_source2;
   logic [3:0]       enq_2_op;
   logic             enq_3_vld;
   logic [3:0]       enq_3_des;
   logic [3:0]       enq_3_source1;
   logic [3:0]       enq_3_source2;
   logic [3:0]       enq_3_op;
   logic             enq_4_vld;
   logic [3:0]       enq_4_des;
   logic [3:0]       enq_4_source1;
   logic [3:0]       enq_4_source2;
   logic [3:0]       enq_4_op;
   logic             enq_rdy;

   logic             ins_in_1_vld;
   logic [3:0]       ins_in_1_des;
   logic [3:0]       ins_in_1_source1;
   logic [3:0]       ins_in_1_source2;
   logic [3:0]       op1;
   logic             ins_in_2_vld;
   logic [3:0]       ins_in_2_des;
   logic [3:0]       ins_in_2_source1;
   logic [3:0]       ins_in_2_source2;
   logic [3:0]       op2;
   logic             ins_in_3_vld;
   logic [3:0]       ins_in_3_des;
   logic [3:0]       ins_in_3_source1;
   logic [3:0]       ins_in_3_source2;
   logic [3:0]       op3;
   logic             ins_in_4_vld;
   logic [3:0]       ins_in_4_des;
   logic [3:0]       ins_in_4_source1;
   logic [3:0]       ins_in_4_source2;
   logic [3:0]       op4;

   logic             ins1_out;
   logic             ins2_out;
   logic             ins3_out;
   logic             ins4_out;

   logic [CNT_W-1:0] count;

   modport master (
      input  flush_en,
      input  enq_1_vld, enq_1_des, enq_1_source1, enq_1_source2, enq_1_op,
      input  enq_2_vld, enq_2_des, enq_2_source1, enq_2_source2, enq_2_op,
      input  enq_3_vld, enq_3_des, enq_3_source1, enq_3_source2, enq_3_op,
      input  enq_4_vld, enq_4_des, enq_4_source1, enq_4_source2, enq_4_op,
      output enq_rdy,
      output ins_in_1_vld, ins_in_1_des, ins_in_1_source1, ins_in_1_source2, op1,
      output ins_in_2_vld, ins_in_2_des, ins_in_2_source1, ins_in_2_source2, op2,
      output ins_in_3_vld, ins_in_3_des, ins_in_3_source1, ins_in_3_source2, op3,
      output ins_in_4_vld, ins_in_4_des, ins_in_4_source1, ins_in_4_source2, op4,
      input  ins1_out, ins2_out, ins3_out, ins4_out,
      output count
   );

   modport slave (
      output flush_en,
      output enq_1_vld, enq_1_des, enq_1_source1, enq_1_source2, enq_1_op,
      output enq_2_vld, enq_2_des, enq_2_source1, enq_2_source2, enq_2_op,
      output enq_3_vld, enq_3_des, enq_3_source1, enq_3_source2, enq_3_op,
      output enq_4_vld, enq_4_des, enq_4_source1, enq_4_source2, enq_4_op,
      input  enq_rdy,
      input  ins_in_1_vld, ins_in_1_des, ins_in_1_source1, ins_in_1_source2, op1,
      input  ins_in_2_vld, ins_in_2_des, ins_in_2_source1, ins_in_2_source2, op2,
      input  ins_in_3_vld, ins_in_3_des, ins_in_3_source1, ins_in_3_source2, op3,
      input  ins_in_4_vld, ins_in_4_des, ins_in_4_source1, ins_in_4_source2, op4,
      output ins1_out, ins2_out, ins3_out, ins4_out,
      input  count
   );

endinterface

// File: rtl/ins_lane_pack.sv
// Packs valid enqueue lanes into a dense array in lane order and reports how many.
// Purely combinational, zero latency; no flow control of its own.
module ins_lane_pack
   import issue_pkg::*;
#(
   parameter int LANES = ISSUE_LANES
) (
   input  logic [LANES-1:0]               lane_vld,
   input  ins_t [LANES-1:0]               lane_ins,
   output ins_t [LANES-1:0]               packed_ins,
   output logic [$clog2(LANES+1)-1:0]     acc_cnt
);

   localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int ACC_W  = $clog2(LANES + 1);

   int fill;

   always_comb begin
      packed_ins = '0;
      fill       = 0;
      for (int i = 0; i < LANES; i++) begin
         if (lane_vld[LIDX_W'(i)]) begin
            packed_ins[LIDX_W'(fill)] = lane_ins[LIDX_W'(i)];
            fill = fill + 1;
         end
      end
      acc_cnt = ACC_W'(fill);
   end

endmodule

// File: rtl/ins_fetch_window.sv
// In-order instruction window: appends packed lanes, removes any subset of the first LANES slots.
// Latency 1 cycle enqueue-to-present; enq_rdy only while registered count leaves room for a full group.
module ins_fetch_window
   import issue_pkg::*;
#(
   parameter int DEPTH = WIN_DEPTH,
   parameter int LANES = ISSUE_LANES
) (
   input  logic                clk,
   input  logic                rst,
   ins_fetch_window_if.master  fw
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int ACC_W  = $clog2(LANES + 1);

   ins_t [DEPTH-1:0]  slot_q;
   ins_t [DEPTH-1:0]  slot_d;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;

   logic [LANES-1:0]  enq_vld;
   ins_t [LANES-1:0]  enq_ins;
   ins_t [LANES-1:0]  pack_ins;
   logic [ACC_W-1:0]  pack_cnt;

   logic [LANES-1:0]  take;
   logic [LANES-1:0]  pres_vld;
   ins_t [LANES-1:0]  pres_ins;
   logic [DEPTH-1:0]  honour;
   logic              enq_rdy;

   int                n_surv;
   int                n_acc;

   assign enq_vld = {fw.enq_4_vld, fw.enq_3_vld, fw.enq_2_vld, fw.enq_1_vld};
   assign enq_ins[0] = '{des: fw.enq_1_des, source1: fw.enq_1_source1,
                         source2: fw.enq_1_source2, op: fw.enq_1_op};
   assign enq_ins[1] = '{des: fw.enq_2_des, source1: fw.enq_2_source1,
                         source2: fw.enq_2_source2, op: fw.enq_2_op};
   assign enq_ins[2] = '{des: fw.enq_3_des, source1: fw.enq_3_source1,
                         source2: fw.enq_3_source2, op: fw.enq_3_op};
   assign enq_ins[3] = '{des: fw.enq_4_des, source1: fw.enq_4_source1,
                         source2: fw.enq_4_source2, op: fw.enq_4_op};
   assign take = {fw.ins4_out, fw.ins3_out, fw.ins2_out, fw.ins1_out};

   ins_lane_pack #(.LANES(LANES)) u_pack (
      .lane_vld   (enq_vld),
      .lane_ins   (enq_ins),
      .packed_ins (pack_ins),
      .acc_cnt    (pack_cnt)
   );

   // Room is judged on the registered count alone so a full group always fits.
   assign enq_rdy = (count_q <= CNT_W'(LANES));

   always_comb begin
      pres_vld = '0;
      pres_ins = '0;
      for (int n = 0; n < LANES; n++) begin
         pres_vld[LIDX_W'(n)] = (int'(count_q) > n);
         pres_ins[LIDX_W'(n)] = pres_vld[LIDX_W'(n)] ? slot_q[IDX_W'(n)] : '0;
      end
   end

   // Strobes on slots that are not presented are dropped here.
   assign honour = DEPTH'(take & pres_vld);

   always_comb begin
      slot_d  = '0;
      count_d = '0;
      n_surv  = 0;
      n_acc   = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((i < int'(count_q)) && !honour[IDX_W'(i)]) begin
            slot_d[IDX_W'(n_surv)] = slot_q[IDX_W'(i)];
            n_surv = n_surv + 1;
         end
      end
      if (enq_rdy) begin
         n_acc = int'(pack_cnt);
         for (int j = 0; j < LANES; j++) begin
            if ((j < n_acc) && ((n_surv + j) < DEPTH)) begin
               slot_d[IDX_W'(n_surv + j)] = pack_ins[LIDX_W'(j)];
            end
         end
      end
      count_d = CNT_W'(n_surv + n_acc);
      if (fw.flush_en) begin
         slot_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q  <= '0;
         count_q <= '0;
      end else begin
         slot_q  <= slot_d;
         count_q <= count_d;
      end
   end

   assign fw.enq_rdy = enq_rdy;
   assign fw.count   = count_q;

   assign fw.ins_in_1_vld     = pres_vld[0];
   assign fw.ins_in_1_des     = pres_ins[0].des;
   assign fw.ins_in_1_source1 = pres_ins[0].source1;
   assign fw.ins_in_1_source2 = pres_ins[0].source2;
   assign fw.op1              = pres_ins[0].op;

   assign fw.ins_in_2_vld     = pres_vld[1];
   assign fw.ins_in_2_des     = pres_ins[1].des;
   assign fw.ins_in_2_source1 = pres_ins[1].source1;
   assign fw.ins_in_2_source2 = pres_ins[1].source2;
   assign fw.op2              = pres_ins[1].op;

   assign fw.ins_in_3_vld     = pres_vld[2];
   assign fw.ins_in_3_des     = pres_ins[2].des;
   assign fw.ins_in_3_source1 = pres_ins[2].source1;
   assign fw.ins_in_3_source2 = pres_ins[2].source2;
   assign fw.op3              = pres_ins[2].op;

   assign fw.ins_in_4_vld     = pres_vld[3];
   assign fw.ins_in_4_des     = pres_ins[3].des;
   assign fw.ins_in_4_source1 = pres_ins[3].source1;
   assign fw.ins_in_4_source2 = pres_ins[3].source2;
   assign fw.op4              = pres_ins[3].op;

endmodule

// File: tb/tb_ins_fetch_window.sv
// Directed vector table plus hand sequences for the instruction fetch window.
module tb_ins_fetch_window;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   ins_fetch_window_if bus();

   ins_fetch_window dut (
      .clk (clk),
      .rst (rst),
      .fw  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        flush;
      logic [3:0]  ev;     // lane valids, bit0 = lane 1
      logic [15:0] ed;     // lane des, [3:0] = lane 1
      logic [3:0]  outs;   // issue strobes, bit0 = ins1_out
      logic [3:0]  x_cnt;
      logic        x_rdy;
      logic [15:0] x_des;  // expected slot des, [3:0] = slot 0
   } vec_t;

   vec_t tbl [25];

   function automatic vec_t mk(input logic r, input logic f, input logic [3:0] ev,
                               input logic [15:0] ed, input logic [3:0] outs,
                               input logic [3:0] xc, input logic xr, input logic [15:0] xd);
      vec_t v;
      v.rst = r; v.flush = f; v.ev = ev; v.ed = ed; v.outs = outs;
      v.x_cnt = xc; v.x_rdy = xr; v.x_des = xd;
      return v;
   endfunction

   function automatic logic [3:0] s1f(input logic [3:0] d); return ~d;        endfunction
   function automatic logic [3:0] s2f(input logic [3:0] d); return d + 4'd3;  endfunction
   function automatic logic [3:0] opf(input logic [3:0] d); return d ^ 4'h5;  endfunction

   task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s row=%0d actual=%h required=%h", nm, row, act, exp);
      end
   endtask

   task automatic set_lane(input int k, input logic v, input logic [3:0] d);
      case (k)
         0: begin bus.enq_1_vld = v; bus.enq_1_des = d; bus.enq_1_source1 = s1f(d);
                  bus.enq_1_source2 = s2f(d); bus.enq_1_op = opf(d); end
         1: begin bus.enq_2_vld = v; bus.enq_2_des = d; bus.enq_2_source1 = s1f(d);
                  bus.enq_2_source2 = s2f(d); bus.enq_2_op = opf(d); end
         2: begin bus.enq_3_vld = v; bus.enq_3_des = d; bus.enq_3_source1 = s1f(d);
                  bus.enq_3_source2 = s2f(d); bus.enq_3_op = opf(d); end
         default: begin bus.enq_4_vld = v; bus.enq_4_des = d; bus.enq_4_source1 = s1f(d);
                  bus.enq_4_source2 = s2f(d); bus.enq_4_op = opf(d); end
      endcase
   endtask

   task automatic apply(input vec_t v);
      rst          = v.rst;
      bus.flush_en = v.flush;
      for (int k = 0; k < 4; k++) set_lane(k, v.ev[k], v.ed[4*k +: 4]);
      bus.ins1_out = v.outs[0];
      bus.ins2_out = v.outs[1];
      bus.ins3_out = v.outs[2];
      bus.ins4_out = v.outs[3];
   endtask

   function automatic logic [16:0] slot_of(input int n);
      case (n)
         0: return {bus.ins_in_1_vld, bus.ins_in_1_des, bus.ins_in_1_source1, bus.ins_in_1_source2, bus.op1};
         1: return {bus.ins_in_2_vld, bus.ins_in_2_des, bus.ins_in_2_source1, bus.ins_in_2_source2, bus.op2};
         2: return {bus.ins_in_3_vld, bus.ins_in_3_des, bus.ins_in_3_source1, bus.ins_in_3_source2, bus.op3};
         default: return {bus.ins_in_4_vld, bus.ins_in_4_des, bus.ins_in_4_source1, bus.ins_in_4_source2, bus.op4};
      endcase
   endfunction

   function automatic logic [16:0] exp_slot(input logic [3:0] cnt, input logic [15:0] xd, input int n);
      logic [3:0] d;
      d = xd[4*n +: 4];
      if (int'(cnt) > n) return {1'b1, d, s1f(d), s2f(d), opf(d)};
      return '0;
   endfunction

   initial begin
      n_chk = 0;
      n_err = 0;
      apply(mk(1, 0, 4'b0000, 16'h0000, 4'b0000, 0, 1, 16'h0000));

      //             rst flush ev       ed        outs     cnt rdy  slot des
      tbl[0]  = mk(1, 0, 4'b0000, 16'h0000, 4'b0000, 4'd0, 1, 16'h0000);
      tbl[1]  = mk(0, 0, 4'b1111, 16'h4321, 4'b0000, 4'd4, 1, 16'h4321);
      tbl[2]  = mk(0, 0, 4'b0000, 16'h0000, 4'b1010, 4'd2, 1, 16'h0031);
      tbl[3]  = mk(1, 0, 4'b1111, 16'h4321, 4'b0001, 4'd0, 1, 16'h0000);
      tbl[4]  = mk(0, 0, 4'b1111, 16'h4321, 4'b0000, 4'd4, 1, 16'h4321);
      tbl[5]  = mk(0, 0, 4'b1111, 16'h8765, 4'b0000, 4'd8, 0, 16'h4321);
      tbl[6]  = mk(0, 0, 4'b1111, 16'hcba9, 4'b0001, 4'd7, 0, 16'h5432);
      tbl[7]  = mk(0, 0, 4'b1111, 16'hcba9, 4'b1111, 4'd3, 1, 16'h0876);
      tbl[8]  = mk(1, 0, 4'b0000, 16'h0000, 4'b0000, 4'd0, 1, 16'h0000);
      tbl[9]  = mk(0, 0, 4'b1111, 16'h4321, 4'b0000, 4'd4, 1, 16'h4321);
      tbl[10] = mk(0, 0, 4'b0101, 16'head9, 4'b0100, 4'd5, 0, 16'h9421);
      tbl[11] = mk(0, 0, 4'b0000, 16'h0000, 4'b1111, 4'd1, 1, 16'h000a);
      tbl[12] = mk(0, 0, 4'b1111, 16'h4321, 4'b0000, 4'd5, 0, 16'h321a);
      tbl[13] = mk(0, 0, 4'b0000, 16'h0000, 4'b0001, 4'd4, 1, 16'h4321);
      tbl[14] = mk(0, 0, 4'b0011, 16'h0065, 4'b0000, 4'd6, 0, 16'h4321);
      tbl[15] = mk(0, 1, 4'b1111, 16'ha987, 4'b0001, 4'd0, 1, 16'h0000);
      tbl[16] = mk(0, 0, 4'b0111, 16'h0321, 4'b0000, 4'd3, 1, 16'h0321);
      tbl[17] = mk(0, 1, 4'b1000, 16'hb000, 4'b0010, 4'd0, 1, 16'h0000);
      tbl[18] = mk(0, 0, 4'b0000, 16'h0000, 4'b1111, 4'd0, 1, 16'h0000);
      tbl[19] = mk(0, 0, 4'b1111, 16'h4321, 4'b0000, 4'd4, 1, 16'h4321);
      tbl[20] = mk(0, 0, 4'b0010, 16'h0050, 4'b0000, 4'd5, 0, 16'h4321);
      tbl[21] = mk(1, 0, 4'b1111, 16'h8765, 4'b0001, 4'd0, 1, 16'h0000);
      tbl[22] = mk(0, 0, 4'b0011, 16'h0087, 4'b0000, 4'd2, 1, 16'h0087);
      tbl[23] = mk(0, 0, 4'b0000, 16'h0000, 4'b1100, 4'd2, 1, 16'h0087);
      tbl[24] = mk(0, 0, 4'b1000, 16'h9000, 4'b0001, 4'd2, 1, 16'h0098);

      for (int r = 0; r < 25; r++) begin
         apply(tbl[r]);
         @(posedge clk);
         #1;
         chk("count", r, 32'(bus.count), 32'(tbl[r].x_cnt));
         chk("enq_rdy", r, 32'(bus.enq_rdy), 32'(tbl[r].x_rdy));
         for (int n = 0; n < 4; n++)
            chk($sformatf("slot%0d", n), r, 32'(slot_of(n)), 32'(exp_slot(tbl[r].x_cnt, tbl[r].x_des, n)));
      end

      // Window holds des 8,9: new entries must not show before the edge.
      apply(mk(0, 0, 4'b1111, 16'h4321, 4'b0000, 4'd0, 0, 16'h0000));
      #1;
      chk("no_bypass_vld3", 100, 32'(bus.ins_in_3_vld), 32'd0);
      chk("no_bypass_count", 100, 32'(bus.count), 32'd2);
      @(posedge clk);
      #1;
      chk("enq_count", 101, 32'(bus.count), 32'd6);
      chk("enq_slot3_des", 101, 32'(bus.ins_in_3_des), 32'd1);

      // Removals this cycle must not open enq_rdy; the offered group is dropped.
      apply(mk(0, 0, 4'b1111, 16'hcccc, 4'b1111, 4'd0, 0, 16'h0000));
      #1;
      chk("rdy_ignores_removal", 102, 32'(bus.enq_rdy), 32'd0);
      @(posedge clk);
      #1;
      chk("drop_count", 103, 32'(bus.count), 32'd2);
      chk("drop_slot1_des", 103, 32'(bus.ins_in_1_des), 32'd3);
      chk("drop_slot2_des", 103, 32'(bus.ins_in_2_des), 32'd4);
      chk("drop_slot3_vld", 103, 32'(bus.ins_in_3_vld), 32'd0);
      chk("drop_rdy", 103, 32'(bus.enq_rdy), 32'd1);

      apply(mk(0, 0, 4'b0000, 16'h0000, 4'b0000, 4'd0, 0, 16'h0000));
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
